// File: rtl/dump_state_pkg.sv
// Shared tracking-engine definitions: state-buffer word map, FSM encoding and
// word counts used by the dump (write-back) side and the fill side.
package dump_state_pkg;

  // State-buffer word addresses, common with the fill logic
  localparam logic [4:0] ADDR_PRN_CONFIG    = 5'd0;
  localparam logic [4:0] ADDR_CARRIER_FREQ  = 5'd1;
  localparam logic [4:0] ADDR_CODE_FREQ     = 5'd2;
  localparam logic [4:0] ADDR_CORR_CONFIG   = 5'd3;
  localparam logic [4:0] ADDR_NH_CONFIG     = 5'd4;
  localparam logic [4:0] ADDR_DUMP_LENGTH   = 5'd5;
  localparam logic [4:0] ADDR_PRN_STATE     = 5'd6;
  localparam logic [4:0] ADDR_PRN_COUNT     = 5'd7;
  localparam logic [4:0] ADDR_CARRIER_PHASE = 5'd8;
  localparam logic [4:0] ADDR_CARRIER_COUNT = 5'd9;
  localparam logic [4:0] ADDR_CODE_PHASE    = 5'd10;
  localparam logic [4:0] ADDR_PRN_CODE      = 5'd11;
  localparam logic [4:0] ADDR_CORR_STATE    = 5'd12;
  localparam logic [4:0] ADDR_MS_DATA_SUM   = 5'd13;
  localparam logic [4:0] ADDR_PRN2_STATE    = 5'd14;
  localparam logic [4:0] ADDR_ACC_STATE     = 5'd15;

  localparam int VAR_ADDR_BASE = 6;
  localparam int ADDR_ACC_BASE = 16;
  localparam int ACC_MAX_WORDS = 8;
  localparam int VAR_WORDS     = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VAR    = 3'd1,
    ST_ACC_RD = 3'd2,
    ST_ACC_WR = 3'd3,
    ST_DONE   = 3'd4
  } dump_fsm_e;

  typedef logic [VAR_WORDS-1:0][31:0] var_words_t;

  function automatic logic [4:0] clamp_count(input logic [3:0] num, input int max_words);
    return (int'(num) > max_words) ? 5'(max_words) : {1'b0, num};
  endfunction

endpackage

// File: rtl/dump_state_if.sv
// State-buffer write port and correlator result read port of the dump sequencer.
interface dump_state_if;
  // Write handshake: state_wr requests a write of state_d4wr at state_addr; the
  // word is accepted in a cycle where state_wr & state_wr_gnt are both high, and
  // until then state_wr, state_addr and state_d4wr stay stable.
  logic        state_wr;
  logic [4:0]  state_addr;
  logic [31:0] state_d4wr;
  logic        state_wr_gnt;

  // Result read: acc_rd strobes acc_addr; acc_data is valid the following cycle.
  logic        acc_valid;
  logic [3:0]  acc_number;
  logic        acc_rd;
  logic [3:0]  acc_addr;
  logic [31:0] acc_data;

  modport master (
    output state_wr, state_addr, state_d4wr, acc_rd, acc_addr,
    input  state_wr_gnt, acc_valid, acc_number, acc_data
  );

  modport slave (
    input  state_wr, state_addr, state_d4wr, acc_rd, acc_addr,
    output state_wr_gnt, acc_valid, acc_number, acc_data
  );
endinterface

// File: rtl/dump_state_word_mux.sv
// Combinational 10:1 x 32 selector of a snapshot word by write index.
module dump_word_mux
  import dump_state_pkg::*;
(
  input  var_words_t  words,
  input  logic [3:0]  sel,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < VAR_WORDS; i++) begin
      if (sel == 4'(i)) word = words[i];
    end
  end

endmodule

// File: rtl/dump_state.sv
// Channel write-back sequencer: snapshots run-time variables and writes them to
// the state buffer; result write-back is built only with DUMP_STATE_ACC_EN.
module dump_state
  import dump_state_pkg::*;
#(
  parameter int ACC_MAX  = ACC_MAX_WORDS,
  parameter int VAR_BASE = VAR_ADDR_BASE,
  parameter int ACC_BASE = ADDR_ACC_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dump_start,
  input  logic [31:0]        prn_state_w,
  input  logic [31:0]        prn_count_w,
  input  logic [31:0]        carrier_phase,
  input  logic [31:0]        carrier_count,
  input  logic [31:0]        code_phase,
  input  logic [31:0]        prn_code_w,
  input  logic [31:0]        corr_state_w,
  input  logic [31:0]        ms_data_sum_w,
  input  logic [31:0]        prn2_state_w,
  input  logic [31:0]        acc_state_w,
  dump_state_if.master       bus,
  output logic               dump_busy,
  output logic               dump_done,
  output dump_fsm_e          dbg_state
);

  dump_fsm_e   state_q, state_d;
  var_words_t  snap_q, snap_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  k_q, k_d;
  logic [4:0]  n_q, n_d;
  logic        accv_q, accv_d;
  logic        cap_q, cap_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] var_word;

  dump_word_mux u_word_mux (
    .words (snap_q),
    .sel   (idx_q),
    .word  (var_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      n_q     <= '0;
      accv_q  <= 1'b0;
      cap_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      n_q     <= n_d;
      accv_q  <= accv_d;
      cap_q   <= cap_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    k_d     = k_q;
    n_d     = n_q;
    accv_d  = accv_q;
    cap_d   = 1'b0;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (dump_start) begin
          snap_d  = {acc_state_w, prn2_state_w, ms_data_sum_w, corr_state_w, prn_code_w,
                     code_phase, carrier_count, carrier_phase, prn_count_w, prn_state_w};
          accv_d  = bus.acc_valid;
          n_d     = clamp_count(bus.acc_number, ACC_MAX);
          idx_d   = '0;
          k_d     = '0;
          state_d = ST_VAR;
        end
      end
      ST_VAR: begin
        if (bus.state_wr_gnt) begin
          if (idx_q == 4'(VAR_WORDS - 1)) begin
`ifdef DUMP_STATE_ACC_EN
            state_d = (accv_q && (n_q != 5'd0)) ? ST_ACC_RD : ST_DONE;
`else
            state_d = ST_DONE;
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
`ifdef DUMP_STATE_ACC_EN
      ST_ACC_RD: begin
        cap_d   = 1'b1;
        state_d = ST_ACC_WR;
      end
      ST_ACC_WR: begin
        // Result buffer data is only valid on entry; keep it for a stalled write.
        if (cap_q) hold_d = bus.acc_data;
        if (bus.state_wr_gnt) begin
          k_d     = k_q + 4'd1;
          state_d = (({1'b0, k_q} + 5'd1) == n_q) ? ST_DONE : ST_ACC_RD;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.state_wr   = 1'b0;
    bus.state_addr = '0;
    bus.state_d4wr = '0;
    bus.acc_rd     = 1'b0;
    bus.acc_addr   = '0;
    dump_done      = 1'b0;
    case (state_q)
      ST_VAR: begin
        bus.state_wr   = 1'b1;
        bus.state_addr = 5'(VAR_BASE) + {1'b0, idx_q};
        bus.state_d4wr = var_word;
      end
`ifdef DUMP_STATE_ACC_EN
      ST_ACC_RD: begin
        bus.acc_rd   = 1'b1;
        bus.acc_addr = k_q;
      end
      ST_ACC_WR: begin
        bus.state_wr   = 1'b1;
        bus.state_addr = 5'(ACC_BASE) + {1'b0, k_q};
        bus.state_d4wr = cap_q ? bus.acc_data : hold_q;
      end
`endif
      ST_DONE: dump_done = 1'b1;
      default: ;
    endcase
  end

  assign dump_busy = (state_q != ST_IDLE);
  assign dbg_state = state_q;

`ifndef DUMP_STATE_ACC_EN
  logic unused_acc;
  assign unused_acc = ^{bus.acc_data, 5'(ACC_BASE)};
`endif

endmodule

// File: tb/tb_dump_state.sv
// Scoreboard bench for dump_state: drivers push expected writes, result reads
// and completion cycles; a negedge monitor pops and compares them.
module tb_dump_state;
  import dump_state_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dump_start = 1'b0;
  logic [31:0] vars [10];
  logic [31:0] res_mem [16];
  logic        dump_busy;
  logic        dump_done;
  dump_fsm_e   dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [36:0] exp_q[$];
  logic [3:0]  exp_rd_q[$];
  int          exp_done_q[$];

  logic        hold_pend = 1'b0;
  logic [36:0] hold_word = '0;

  dump_state_if bus();

  dump_state dut (
    .clk           (clk),
    .rst           (rst),
    .dump_start    (dump_start),
    .prn_state_w   (vars[0]),
    .prn_count_w   (vars[1]),
    .carrier_phase (vars[2]),
    .carrier_count (vars[3]),
    .code_phase    (vars[4]),
    .prn_code_w    (vars[5]),
    .corr_state_w  (vars[6]),
    .ms_data_sum_w (vars[7]),
    .prn2_state_w  (vars[8]),
    .acc_state_w   (vars[9]),
    .bus           (bus),
    .dump_busy     (dump_busy),
    .dump_done     (dump_done),
    .dbg_state     (dbg_state)
  );

  // clock / cycle counter / result buffer model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.acc_rd) bus.acc_data <= res_mem[bus.acc_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      hold_pend <= 1'b0;
    end else begin
      if (bus.state_wr) begin
        if (hold_pend) chk("hold_stable", {bus.state_addr, bus.state_d4wr}, hold_word);
        if (bus.state_wr_gnt) begin
          hold_pend <= 1'b0;
          if (exp_q.size() == 0) fail_evt("write");
          else chk("write", {bus.state_addr, bus.state_d4wr}, exp_q.pop_front());
        end else begin
          hold_pend <= 1'b1;
          hold_word <= {bus.state_addr, bus.state_d4wr};
        end
      end
      if (bus.acc_rd) begin
        if (exp_rd_q.size() == 0) fail_evt("acc_rd");
        else chk("acc_addr", bus.acc_addr, exp_rd_q.pop_front());
      end
      if (dump_done) begin
        if (exp_done_q.size() == 0) fail_evt("dump_done");
        else chk("done_cycle", cyc, exp_done_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic set_vars(input logic [31:0] base);
    for (int i = 0; i < 10; i++) vars[i] = base + 32'h0101_0001 * i;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_dump(input logic av, input logic [3:0] num, input int extra, output int c0);
    int n;
    @(posedge clk);
    #1;
    dump_start     = 1'b1;
    bus.acc_valid  = av;
    bus.acc_number = num;
    c0 = cyc;
    for (int i = 0; i < 10; i++) exp_q.push_back({5'(6 + i), vars[i]});
    n = 0;
`ifdef DUMP_STATE_ACC_EN
    if (av) n = (num > 4'd8) ? 8 : int'(num);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({5'(16 + k), res_mem[k]});
      exp_rd_q.push_back(4'(k));
    end
`endif
    exp_done_q.push_back(c0 + 11 + 2 * n + extra);
    @(posedge clk);
    #1;
    dump_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!dump_busy && exp_q.size() == 0 && exp_rd_q.size() == 0 && exp_done_q.size() == 0) break;
    end
    if (t == 300) fail_evt({name, "_timeout"});
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_state_wr"}, bus.state_wr, 1'b0);
    chk({name, "_state_addr"}, bus.state_addr, 5'd0);
    chk({name, "_state_d4wr"}, bus.state_d4wr, 32'd0);
    chk({name, "_acc_rd"}, bus.acc_rd, 1'b0);
    chk({name, "_acc_addr"}, bus.acc_addr, 4'd0);
    chk({name, "_busy"}, dump_busy, 1'b0);
    chk({name, "_done"}, dump_done, 1'b0);
    chk({name, "_fsm"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 16; i++) res_mem[i] = 32'hA0 + i;
    set_vars(32'h1111_0000);
    bus.state_wr_gnt = 1'b1;
    bus.acc_valid    = 1'b0;
    bus.acc_number   = 4'd0;
    bus.acc_data     = '0;

    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;

    // variables only
    start_dump(1'b0, 4'd0, 0, c0);
    wait_idle("vars_only");

    // three results
    set_vars(32'h2222_0000);
    start_dump(1'b1, 4'd3, 0, c0);
    wait_idle("acc3");

    // grant withheld for 4 cycles on address 9
    set_vars(32'h3333_0000);
    start_dump(1'b0, 4'd0, 4, c0);
    goto_cycle(c0 + 4);
    bus.state_wr_gnt = 1'b0;
    @(negedge clk);
    chk("stall_addr", bus.state_addr, 5'd9);
    goto_cycle(c0 + 8);
    bus.state_wr_gnt = 1'b1;
    wait_idle("stall");

    // result count clamped to 8
    set_vars(32'h4444_0000);
    start_dump(1'b1, 4'd12, 0, c0);
    wait_idle("acc12");

    // inputs change after start, second start ignored
    set_vars(32'h5555_0000);
    start_dump(1'b1, 4'd2, 0, c0);
    set_vars(32'h6666_0000);
    goto_cycle(c0 + 5);
    chk("busy_mid", dump_busy, 1'b1);
    dump_start = 1'b1;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    wait_idle("snapshot");

    // reset mid-sequence, then a clean run
    set_vars(32'h7777_0000);
    start_dump(1'b1, 4'd3, 0, c0);
    goto_cycle(c0 + 4);
    #2;
    rst = 1'b1;
    #1;
    check_quiet("midrst");
    exp_q.delete();
    exp_rd_q.delete();
    exp_done_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    set_vars(32'h8888_0000);
    start_dump(1'b1, 4'd2, 0, c0);
    wait_idle("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dump_state.md
# dump_state

Write-back sequencer for one physical tracking channel. On a dump request it snapshots the channel's run-time variables and writes them back to the channel state buffer. Addresses 6–15 are written first. When coherent results are ready, correlator results follow at addresses 16–23. It is the write-side counterpart of the state fill logic and sits between the correlator datapath and the state buffer write port.

## Interface
Parameters:
- `ACC_MAX`, 8: maximum correlator result words written back; must be ≤16.
- `VAR_BASE`, 6: first variable word address.
- `ACC_BASE`, 16: first correlator result word address.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `dump_start`  in  1  one-cycle request to dump the current channel
- `prn_state_w`, `prn_count_w`, `carrier_phase`, `carrier_count`, `code_phase`, `prn_code_w`, `corr_state_w`, `ms_data_sum_w`, `prn2_state_w`, `acc_state_w`  in  32 each  channel variables, packed per state-buffer word
- `acc_valid`  in  1  coherent results ready for write-back
- `acc_number`  in  4  number of result words to write
- `acc_rd`  out  1  result buffer read strobe
- `acc_addr`  out  4  result buffer read index
- `acc_data`  in  32  result data, valid the cycle after `acc_rd`
- `state_wr`  out  1  state buffer write request
- `state_addr`  out  5  write address
- `state_d4wr`  out  32  write data
- `state_wr_gnt`  in  1  write accepted this cycle
- `dump_busy`  out  1  sequence in progress
- `dump_done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, VAR, ACC_RD, ACC_WR, DONE.
- **IDLE**
  - When `dump_start` is high, register all ten variable words into a snapshot.
  - Latch `acc_valid` and `min(acc_number, ACC_MAX)` into a result count `n`.
  - Go to VAR.
- **VAR**
  - `state_wr` is high, `state_addr` = `VAR_BASE` + word index (0..9), `state_d4wr` = snapshot word.
  - The word index advances only when `state_wr & state_wr_gnt` is true.
  - After index 9 is accepted: if `n` = 0 or the latched `acc_valid` = 0, go to DONE; otherwise go to ACC_RD.
- **ACC_RD**
  - Pulse `acc_rd` for one cycle with `acc_addr` = `k`; `state_wr` is low.
  - Go to ACC_WR.
- **ACC_WR**
  - Capture `acc_data` on entry.
  - `state_wr` is high with `state_addr` = `ACC_BASE` + `k`, held until granted.
  - On grant: increment `k`; if `k` = `n`, go to DONE, else go to ACC_RD.
- **DONE**
  - `dump_done` high for one cycle, then go to IDLE.
- `dump_busy` is high in every state except IDLE.
- `dump_start` is ignored while `dump_busy` is high; it is not queued.
- Channel inputs may change freely after the start cycle; only the snapshot is written.
- While a write is not granted, `state_addr` and `state_d4wr` are held stable.
- Reset mid-sequence:
  - Returns to IDLE immediately; no partial-completion pulse.
  - The buffer may hold a partially written channel; software re-dumps.

## Timing
- Reset values: all outputs 0; FSM in IDLE; snapshot, `k` and `n` cleared.
- Cycle numbering with `dump_start` at cycle 0 and `state_wr_gnt` tied high:
  - Variable writes occupy cycles 1–10 (addresses 6–15).
  - Each result word takes 2 cycles: `acc_rd` at cycle 9+2k+2, write at cycle 10+2k+2.
  - `dump_done` is at cycle 11 without results, or cycle 11+2n with results.
- Each cycle of `state_wr_gnt` low during a pending write adds exactly one cycle.
- `acc_addr` is 4 bits. With `ACC_MAX` = 8, `state_addr` never exceeds 23.

## Configuration
- `DUMP_STATE_ACC_EN` defined:
  - Result write-back is included as described above.
- `DUMP_STATE_ACC_EN` undefined:
  - ACC_RD and ACC_WR are removed; VAR always goes to DONE.
  - `acc_rd` and `acc_addr` are tied to 0; `acc_valid`, `acc_number` and `acc_data` are unused.
  - `dump_done` is at cycle 11.

## Structure
- Shared tracking-engine package holds:
  - State-word address constants 0–15 (common with the fill side), plus `ACC_BASE` and `ACC_MAX`.
  - The FSM state enum.
  - The variable word count (10).
- One sub-module, `dump_word_mux`, selects the snapshot word by index. It is combinational, 10:1 × 32.

## Test plan
- `dump_start` with `acc_valid` = 0 and grant always high:
  - Writes at addresses 6..15 in cycles 1–10 with the snapshot values.
  - `dump_done` at cycle 11; `acc_rd` never asserted.
- `acc_valid` = 1, `acc_number` = 3, results 0xA0..0xA2:
  - Addresses 16, 17, 18 receive 0xA0–0xA2.
  - `dump_done` at cycle 17.
- Grant held low for 4 cycles on address 9:
  - Address and data stay stable throughout.
  - `dump_done` is delayed by exactly 4 cycles; no duplicate write is accepted.
- `acc_number` = 12 → exactly 8 result writes (addresses 16–23).
- Input variables change on cycle 1 and a second `dump_start` is pulsed at cycle 5:
  - All written values equal the cycle-0 snapshot.
  - The second start is ignored.
- `rst` asserted at cycle 4 → all outputs 0 immediately; the next `dump_start` runs a full clean sequence.
